// File: rtl/l1_mem_pkg.sv
// Shared types and line geometry for the L1 refill responder.
package l1_mem_pkg;

    localparam int LINE_BYTES = 8;
    localparam int LINE_BITS  = 64;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        FILL_DONE = 3'd2,
        WR        = 3'd3,
        WR_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/line_assembler.sv
// Byte counter plus 64-bit line register; each loaded byte lands in the
// slot selected by the counter, then the counter advances.
module line_assembler
    import l1_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load_en,
    input  logic [7:0]           byte_in,
    output logic [LINE_BITS-1:0] line,
    output logic [CNT_W-1:0]     cnt,
    output logic                 last
);

    logic [LINE_BITS-1:0] line_q, line_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Next line/counter: clear wins over a load, counter wraps 7 -> 0 naturally.
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (clear) begin
            line_d = '0;
            cnt_d  = '0;
        end else if (load_en) begin
            line_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d                        = cnt_q + CNT_W'(1);
        end
    end

    // Register the line and counter; reset discards any partial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line = line_q;
    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(LINE_BYTES - 1));

endmodule

// File: rtl/l1_refill_responder.sv
// Memory-side responder for the L1: 8-byte line fills and single-byte
// write-throughs over a byte-wide req/ack backing-memory port.
module l1_refill_responder
    import l1_mem_pkg::*;
#(
    parameter int TamAddr = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fill_req,
    input  logic [TamAddr-1:0]   fill_addr,
    input  logic                 wr_mem,
    input  logic [TamAddr-1:0]   wr_addr,
    input  logic [7:0]           wr_byte,
    output logic [LINE_BITS-1:0] data_write,
    output logic                 dataComplete,
    output logic                 writeComplete,
    output logic                 busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [TamAddr-1:0]   mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ack
);

    localparam logic [TamAddr-1:0] OFS_MASK = TamAddr'(LINE_BYTES - 1);

    state_e             state_q, state_d;
    logic [TamAddr-1:0] base_q, base_d;
    logic [TamAddr-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic               dc_q, dc_d;
    logic               wc_q, wc_d;
    logic               busy_q, busy_d;

    logic               asm_clear, asm_load, asm_last;
    logic [CNT_W-1:0]   asm_cnt, cnt_inc;

    assign cnt_inc = asm_cnt + CNT_W'(1);

    line_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .load_en (asm_load),
        .byte_in (mem_rdata),
        .line    (data_write),
        .cnt     (asm_cnt),
        .last    (asm_last)
    );

    // Next-state and next-output logic; all outputs are registered so the
    // next fill address is already on mem_addr the cycle after an ack.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        dc_d        = 1'b0;
        wc_d        = 1'b0;
        asm_clear   = 1'b0;
        asm_load    = 1'b0;
        case (state_q)
            IDLE: begin
                // Write first so a fill requested alongside it reads fresh data.
                if (wr_mem) begin
                    state_d     = WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_byte;
                end else if (fill_req) begin
                    state_d    = FILL;
                    base_d     = fill_addr & ~OFS_MASK;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = fill_addr & ~OFS_MASK;
                    asm_clear  = 1'b1;
                end
            end
            FILL: begin
                if (mem_req_q && mem_ack) begin
                    asm_load = 1'b1;
                    if (asm_last) begin
                        state_d    = FILL_DONE;
                        mem_req_d  = 1'b0;
                        mem_addr_d = '0;
                        dc_d       = 1'b1;
                    end else begin
                        mem_addr_d = base_q | TamAddr'(cnt_inc);
                    end
                end
            end
            FILL_DONE: state_d = IDLE;
            WR: begin
                if (mem_req_q && mem_ack) begin
                    state_d     = WR_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    wc_d        = 1'b1;
                end
            end
            WR_DONE: state_d = IDLE;
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs; reset drops mem_req without waiting for ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            dc_q        <= 1'b0;
            wc_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            dc_q        <= dc_d;
            wc_q        <= wc_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign dataComplete  = dc_q;
    assign writeComplete = wc_q;
    assign busy          = busy_q;

endmodule
